// File: rtl/paddle_motion_ctrl_if.sv
// Paddle motion bundle: scan position, buttons in; frame strobe and paddle extent out.
// master = scan/button source, slave = paddle_motion_ctrl.
interface paddle_motion_ctrl_if;
  logic       p_tick;
  logic [9:0] x;
  logic [9:0] y;
  logic       up;
  logic       down;
  logic       refresh_tick;
  logic [9:0] pad_y_t;
  logic [9:0] pad_y_b;
  logic       moving;

  modport master (
    output p_tick, x, y, up, down,
    input  refresh_tick, pad_y_t, pad_y_b, moving
  );

  modport slave (
    input  p_tick, x, y, up, down,
    output refresh_tick, pad_y_t, pad_y_b, moving
  );
endinterface

// File: rtl/paddle_motion_ctrl.sv
// Per-frame paddle sequencer: frame strobe from scan position, IDLE/ACCEL/CRUISE speed FSM, clamped top row.
// Latency 2 clk from the qualifying p_tick to the new pad_y_t; no backpressure, buttons are sampled only on the strobe.
module paddle_motion_ctrl #(
  parameter int V_ACTIVE     = 480,
  parameter int PAD_H        = 72,
  parameter int Y_TOP_INIT   = 204,
  parameter int STEP_MIN     = 1,
  parameter int STEP_MAX     = 8,
  parameter int ACCEL_FRAMES = 4
) (
  input logic               clk_100MHz,
  input logic               reset,
  paddle_motion_ctrl_if.slave bus
);

  localparam int SW = $clog2(STEP_MAX + 1);
  localparam int CW = $clog2(ACCEL_FRAMES + 1);
  localparam logic signed [10:0] Y_MAX = 11'(V_ACTIVE - PAD_H);

  typedef enum logic [1:0] {IDLE, ACCEL, CRUISE} state_t;
  typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DOWN} dir_t;

  state_t          state_q, state_d;
  dir_t            last_dir_q, last_dir_d, dir;
  logic [SW-1:0]   step_q, step_d, move;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [9:0]      pad_q, pad_d;
  logic            tick_q;
  logic signed [10:0] pos_cur, pos_up, pos_dn, mv;

  always_ff @(posedge clk_100MHz) begin
    if (!reset) begin
      state_q    <= IDLE;
      last_dir_q <= DIR_NONE;
      step_q     <= '0;
      cnt_q      <= '0;
      pad_q      <= 10'(Y_TOP_INIT);
      tick_q     <= 1'b0;
    end else begin
      // Line V_ACTIVE+1 is inside vertical blanking, so the update never tears the visible paddle.
      tick_q     <= bus.p_tick && (bus.x == 10'd0) && (bus.y == 10'(V_ACTIVE + 1));
      state_q    <= state_d;
      last_dir_q <= last_dir_d;
      step_q     <= step_d;
      cnt_q      <= cnt_d;
      pad_q      <= pad_d;
    end
  end

  always_comb begin
    dir = DIR_NONE;
    if (tick_q) begin
      if (bus.up && !bus.down)      dir = DIR_UP;
      else if (bus.down && !bus.up) dir = DIR_DOWN;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_dir_d = last_dir_q;
    step_d     = step_q;
    cnt_d      = cnt_q;
    move       = '0;
    if (tick_q) begin
      if (dir == DIR_NONE) begin
        state_d = IDLE;
        step_d  = '0;
        cnt_d   = '0;
      end else if (state_q == IDLE || dir != last_dir_q) begin
        // A fresh press and a reversal both restart from the slowest speed.
        move       = SW'(STEP_MIN);
        step_d     = SW'(STEP_MIN);
        cnt_d      = CW'(1);
        last_dir_d = dir;
        state_d    = (STEP_MIN == STEP_MAX) ? CRUISE : ACCEL;
      end else begin
        unique case (state_q)
          ACCEL: begin
            if (cnt_q == CW'(ACCEL_FRAMES)) begin
              step_d = step_q + SW'(1);
              cnt_d  = CW'(1);
            end else begin
              cnt_d  = cnt_q + CW'(1);
            end
            move = step_d;
            if (step_d == SW'(STEP_MAX)) state_d = CRUISE;
          end
          CRUISE:  move = SW'(STEP_MAX);
          default: move = '0;
        endcase
      end
    end
  end

  always_comb begin
    pos_cur = {1'b0, pad_q};
    mv      = 11'(move);
    pos_up  = pos_cur - mv;
    pos_dn  = pos_cur + mv;
    pad_d   = pad_q;
    if (dir == DIR_UP)
      pad_d = (pos_up < 11'sd0) ? 10'd0 : pos_up[9:0];
    else if (dir == DIR_DOWN)
      pad_d = (pos_dn > Y_MAX) ? Y_MAX[9:0] : pos_dn[9:0];
  end

  assign bus.refresh_tick = tick_q;
  assign bus.pad_y_t      = pad_q;
  assign bus.pad_y_b      = pad_q + 10'(PAD_H - 1);
  assign bus.moving       = (state_q != IDLE);

endmodule

// File: tb/tb_paddle_motion_ctrl.sv
// Scoreboarded bench for paddle_motion_ctrl using shortened frames and a frame-count speed model.
module tb_paddle_motion_ctrl;
  localparam int V_ACTIVE     = 480;
  localparam int PAD_H        = 72;
  localparam int Y_TOP_INIT   = 204;
  localparam int STEP_MIN     = 1;
  localparam int STEP_MAX     = 8;
  localparam int ACCEL_FRAMES = 4;
  localparam int FL           = 24;

  typedef struct {
    int cyc;
    int pad;
    bit mov;
  } exp_t;

  logic clk_100MHz = 1'b0;
  logic reset      = 1'b0;
  paddle_motion_ctrl_if bus();

  paddle_motion_ctrl #(
    .V_ACTIVE(V_ACTIVE), .PAD_H(PAD_H), .Y_TOP_INIT(Y_TOP_INIT),
    .STEP_MIN(STEP_MIN), .STEP_MAX(STEP_MAX), .ACCEL_FRAMES(ACCEL_FRAMES)
  ) dut (
    .clk_100MHz(clk_100MHz),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  exp_t exp_q[$];
  int   cyc = 0;
  bit   rst_sampled = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk_100MHz) begin
    cyc         <= cyc + 1;
    rst_sampled <= reset;
  end

  // Reference model: speed is a function of how many consecutive frames the same direction was held.
  int m_pad = Y_TOP_INIT;
  int m_n   = 0;
  int m_dir = 0;

  function automatic void model_reset();
    m_pad = Y_TOP_INIT;
    m_n   = 0;
    m_dir = 0;
  endfunction

  function automatic void model_step(input bit u, input bit d);
    int dir, step;
    dir = (u && !d) ? -1 : ((d && !u) ? 1 : 0);
    if (dir == 0) m_n = 0;
    else if (m_n > 0 && dir == m_dir) m_n = (m_n < 1000) ? m_n + 1 : m_n;
    else begin
      m_n   = 1;
      m_dir = dir;
    end
    if (m_n > 0) begin
      step = STEP_MIN + (m_n - 1) / ACCEL_FRAMES;
      if (step > STEP_MAX) step = STEP_MAX;
      m_pad = m_pad + dir * step;
      if (m_pad < 0) m_pad = 0;
      if (m_pad > V_ACTIVE - PAD_H) m_pad = V_ACTIVE - PAD_H;
    end
  endfunction

  task automatic frame(input bit u, input bit d, input bit noisy, input bit do_rst);
    for (int c = 0; c < FL; c++) begin
      @(posedge clk_100MHz);
      #1;
      bus.p_tick = ((c % 4) == 0);
      bus.x      = 10'($urandom_range(0, 799));
      bus.y      = 10'($urandom_range(0, 524));
      if (bus.p_tick && bus.x == 10'd0 && bus.y == 10'(V_ACTIVE + 1)) bus.y = 10'(V_ACTIVE);
      if (c == 0) begin
        bus.p_tick = 1'b1;
        bus.x      = 10'd0;
        bus.y      = 10'(V_ACTIVE + 1);
        bus.up     = u;
        bus.down   = d;
        if (do_rst) begin
          reset = 1'b0;
          model_reset();
        end else begin
          model_step(u, d);
          exp_q.push_back('{cyc: cyc + 1, pad: m_pad, mov: (m_n > 0)});
        end
      end else if (c == 1) begin
        reset    = 1'b1;
        bus.up   = u;
        bus.down = d;
      end else begin
        if (c == 2) begin
          bus.p_tick = 1'b0;
          bus.x      = 10'd0;
          bus.y      = 10'(V_ACTIVE + 1);
        end
        if (noisy) begin
          bus.up   = 1'($urandom_range(0, 1));
          bus.down = 1'($urandom_range(0, 1));
        end
      end
    end
  endtask

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, expv);
    end
  endtask

  int   rd_idx  = 0;
  int   cur_pad = Y_TOP_INIT;
  bit   cur_mov = 1'b0;
  bit   pend    = 1'b0;
  exp_t pexp;

  always @(negedge clk_100MHz) begin
    if (!rst_sampled) begin
      chk("reset refresh_tick", int'(bus.refresh_tick), 0);
      chk("reset pad_y_t", int'(bus.pad_y_t), Y_TOP_INIT);
      chk("reset pad_y_b", int'(bus.pad_y_b), Y_TOP_INIT + PAD_H - 1);
      chk("reset moving", int'(bus.moving), 0);
      cur_pad = Y_TOP_INIT;
      cur_mov = 1'b0;
      pend    = 1'b0;
      rd_idx  = exp_q.size();
    end else begin
      if (pend) begin
        chk("pad_y_t update", int'(bus.pad_y_t), pexp.pad);
        chk("pad_y_b update", int'(bus.pad_y_b), pexp.pad + PAD_H - 1);
        chk("moving update", int'(bus.moving), int'(pexp.mov));
        cur_pad = pexp.pad;
        cur_mov = pexp.mov;
        pend    = 1'b0;
      end else begin
        chk("pad_y_t steady", int'(bus.pad_y_t), cur_pad);
        chk("moving steady", int'(bus.moving), int'(cur_mov));
      end
      if (rd_idx < exp_q.size() && cyc > exp_q[rd_idx].cyc) begin
        chk("strobe missing", cyc, exp_q[rd_idx].cyc);
        rd_idx++;
      end
      if (bus.refresh_tick) begin
        if (rd_idx < exp_q.size()) begin
          chk("strobe cycle", cyc, exp_q[rd_idx].cyc);
          pexp = exp_q[rd_idx];
          rd_idx++;
          pend = 1'b1;
        end else begin
          chk("unexpected strobe", int'(bus.refresh_tick), 0);
        end
      end
    end
  end

  initial begin
    bus.p_tick = 1'b0;
    bus.x      = 10'd0;
    bus.y      = 10'd0;
    bus.up     = 1'b0;
    bus.down   = 1'b0;
    reset      = 1'b0;
    repeat (10) @(posedge clk_100MHz);
    #1;
    reset = 1'b1;
    model_reset();
    repeat (3) @(posedge clk_100MHz);

    repeat (8)  frame(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (40) frame(1'b1, 1'b0, 1'b0, 1'b0);
    frame(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (70) frame(1'b0, 1'b1, 1'b0, 1'b0);
    frame(1'b0, 1'b0, 1'b0, 1'b0);

    repeat (10) frame(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3)  frame(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (2)  frame(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (3)  frame(1'b0, 1'b0, 1'b1, 1'b0);

    for (int b = 0; b < 40; b++) begin
      int len, sel;
      bit nz;
      len = $urandom_range(1, 12);
      sel = $urandom_range(0, 3);
      nz  = 1'($urandom_range(0, 1));
      repeat (len) frame(sel[0], sel[1], nz, 1'b0);
    end

    frame(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (31) frame(1'b0, 1'b1, 1'b0, 1'b0);
    frame(1'b0, 1'b1, 1'b0, 1'b1);
    repeat (3) frame(1'b1, 1'b0, 1'b1, 1'b0);

    repeat (FL) @(posedge clk_100MHz);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
